// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter that shares one SDRAM controller port among
// NUM_M requesters. Bursts are locked to the owner for as long as it holds cyc.
// A stall watchdog raises a one-cycle error if the slave stops acknowledging.
module sdrc_wb_arbiter #(
    parameter int NUM_M   = 4,
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    // requester side, fields packed by requester index
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*AW-1:0]     m_adr_i,
    input  logic [NUM_M*DW-1:0]     m_dat_i,
    input  logic [NUM_M*DW/8-1:0]   m_sel_i,
    output logic [DW-1:0]           m_dat_o,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    // SDRAM controller side
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [AW-1:0]           s_adr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [DW/8-1:0]         s_sel_o,
    input  logic [DW-1:0]           s_dat_i,
    input  logic                    s_ack_i,
    // status
    output logic [NUM_M-1:0]        gnt_o,
    output logic                    busy_o
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(NUM_M);
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        ERR
    } state_t;

    state_t         state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  gnt_idx;
    logic [CW-1:0]  stall_cnt;

    logic           sel_found;
    logic [IW-1:0]  sel_idx;
    logic [IW:0]    cand;
    logic [IW-1:0]  rr_next;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_M; i++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_M))
                cand = cand - (IW+1)'(NUM_M);
            if (!sel_found && m_cyc_i[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    assign rr_next = (sel_idx == IW'(NUM_M - 1)) ? '0 : sel_idx + 1'b1;

    // Arbitration FSM with grant, pointer, stall watchdog and error pulse.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            state     <= IDLE;
            gnt_o     <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            m_err_o   <= '0;
        end else begin
            m_err_o <= '0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state     <= OWN;
                        gnt_o     <= NUM_M'(1) << sel_idx;
                        gnt_idx   <= sel_idx;
                        rr_ptr    <= rr_next;
                        stall_cnt <= '0;
                    end
                end
                OWN: begin
                    if (!m_cyc_i[gnt_idx]) begin
                        state <= IDLE;
                        gnt_o <= '0;
                    end else if (stall_cnt == CW'(TIMEOUT)) begin
                        state   <= ERR;
                        m_err_o <= gnt_o;
                    end
                    if (s_ack_i)
                        stall_cnt <= '0;
                    else if (s_stb_o && stall_cnt != '1)
                        stall_cnt <= stall_cnt + 1'b1;
                end
                ERR: begin
                    if (!m_cyc_i[gnt_idx]) begin
                        state <= IDLE;
                        gnt_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave-side mux: only the owner reaches the controller, and only in OWN.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (state == OWN) begin
            s_cyc_o = m_cyc_i[gnt_idx];
            s_stb_o = m_stb_i[gnt_idx];
            s_we_o  = m_we_i[gnt_idx];
            s_adr_o = m_adr_i[int'(gnt_idx)*AW +: AW];
            s_dat_o = m_dat_i[int'(gnt_idx)*DW +: DW];
            s_sel_o = m_sel_i[int'(gnt_idx)*SW +: SW];
        end
    end

    // Ack passes straight through to the owner; late acks outside OWN vanish.
    assign m_ack_o = (state == OWN && s_ack_i) ? gnt_o : '0;
    assign m_dat_o = s_dat_i;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Directed bench for sdrc_wb_arbiter: single request, fairness, burst lock,
// timeout, ack-with-drop hand-over and asynchronous reset.
module tb_sdrc_wb_arbiter;

    localparam int NUM_M = 4;
    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;

    logic                  clk;
    logic                  rst;
    logic [NUM_M-1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [NUM_M*AW-1:0]   m_adr_i;
    logic [NUM_M*DW-1:0]   m_dat_i;
    logic [NUM_M*SW-1:0]   m_sel_i;
    logic [DW-1:0]         m_dat_o;
    logic [NUM_M-1:0]      m_ack_o, m_err_o;
    logic                  s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]         s_adr_o;
    logic [DW-1:0]         s_dat_o;
    logic [SW-1:0]         s_sel_o;
    logic [DW-1:0]         s_dat_i;
    logic                  s_ack_i;
    logic [NUM_M-1:0]      gnt_o;
    logic                  busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    sdrc_wb_arbiter #(
        .NUM_M  (NUM_M),
        .AW     (AW),
        .DW     (DW),
        .TIMEOUT(15)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .gnt_o   (gnt_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag);
        check({tag, " gnt"},   gnt_o,   4'b0000);
        check({tag, " busy"},  busy_o,  1'b0);
        check({tag, " s_cyc"}, s_cyc_o, 1'b0);
        check({tag, " s_stb"}, s_stb_o, 1'b0);
        check({tag, " ack"},   m_ack_o, 4'b0000);
        check({tag, " err"},   m_err_o, 4'b0000);
    endtask

    initial begin
        logic [NUM_M-1:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        rst     = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        for (int i = 0; i < NUM_M; i++) begin
            m_adr_i[i*AW +: AW] = AW'(32'h100 + i);
            m_dat_i[i*DW +: DW] = 32'hA000_0000 + i;
            m_sel_i[i*SW +: SW] = SW'(i + 1);
        end

        // Reset state
        #12;
        idle_checks("reset");
        rst = 1'b0;
        step();

        // Single request from master 2
        m_cyc_i = 4'b0100;
        m_stb_i = 4'b0100;
        m_we_i  = 4'b0100;
        #1;
        check("single pre-grant gnt", gnt_o, 4'b0000);
        step();
        check("single gnt",   gnt_o,   4'b0100);
        check("single s_cyc", s_cyc_o, 1'b1);
        check("single s_stb", s_stb_o, 1'b1);
        check("single s_we",  s_we_o,  1'b1);
        check("single s_adr", s_adr_o, 26'h102);
        check("single s_dat", s_dat_o, 32'hA000_0002);
        check("single s_sel", s_sel_o, 4'h3);
        check("single busy",  busy_o,  1'b1);
        check("single ack idle", m_ack_o, 4'b0000);
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        #1;
        check("single ack",   m_ack_o, 4'b0100);
        check("single rdata", m_dat_o, 32'hDEAD_BEEF);
        step();
        s_ack_i = 1'b0;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        step();
        idle_checks("single release");

        // Fairness: fresh reset so the search starts at index 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("fair gnt %0d", k), gnt_o, order[k]);
            s_ack_i = 1'b1;
            m_cyc_i = m_cyc_i & ~order[k];
            #1;
            check($sformatf("fair ack %0d", k), m_ack_o, order[k]);
            step();
            s_ack_i = 1'b0;
            check($sformatf("fair dead gnt %0d", k), gnt_o, 4'b0000);
            check($sformatf("fair dead busy %0d", k), busy_o, 1'b0);
            m_cyc_i = m_cyc_i | order[k];
        end

        // Burst lock: master 1 owns for 8 beats while master 0 waits
        m_cyc_i = 4'b0000;
        m_stb_i = 4'b0000;
        step();
        m_cyc_i = 4'b0010;
        m_stb_i = 4'b0010;
        step();
        check("burst gnt", gnt_o, 4'b0010);
        m_cyc_i = 4'b0011;
        m_stb_i = 4'b0011;
        for (int b = 0; b < 8; b++) begin
            s_ack_i = 1'b1;
            #1;
            check($sformatf("burst ack %0d", b), m_ack_o, 4'b0010);
            step();
            check($sformatf("burst hold %0d", b), gnt_o, 4'b0010);
        end
        s_ack_i = 1'b0;
        m_cyc_i = 4'b0001;
        m_stb_i = 4'b0001;
        step();
        check("burst dead gnt", gnt_o, 4'b0000);
        step();
        check("burst next gnt", gnt_o, 4'b0001);
        m_cyc_i = '0;
        m_stb_i = '0;
        step();

        // Timeout: master 2 strobes with no ack
        m_cyc_i = 4'b0100;
        m_stb_i = 4'b0100;
        step();
        check("to gnt", gnt_o, 4'b0100);
        for (int c = 0; c < 15; c++) begin
            step();
            check($sformatf("to stall err %0d", c), m_err_o, 4'b0000);
            check($sformatf("to stall stb %0d", c), s_stb_o, 1'b1);
        end
        step();
        check("to err",   m_err_o, 4'b0100);
        check("to s_stb", s_stb_o, 1'b0);
        check("to s_cyc", s_cyc_o, 1'b0);
        check("to gnt held", gnt_o, 4'b0100);
        check("to busy",  busy_o,  1'b1);
        step();
        check("to err once", m_err_o, 4'b0000);
        check("to gnt held2", gnt_o, 4'b0100);
        s_ack_i = 1'b1;
        #1;
        check("to late ack", m_ack_o, 4'b0000);
        s_ack_i = 1'b0;
        m_cyc_i = '0;
        m_stb_i = '0;
        step();
        idle_checks("to release");

        // Ack and cyc drop together by master 3, master 0 pending
        m_cyc_i = 4'b1001;
        m_stb_i = 4'b1001;
        step();
        check("drop gnt3", gnt_o, 4'b1000);
        s_ack_i = 1'b1;
        m_cyc_i = 4'b0001;
        m_stb_i = 4'b0001;
        #1;
        check("drop ack3", m_ack_o, 4'b1000);
        step();
        check("drop dead gnt", gnt_o, 4'b0000);
        check("drop idle late ack", m_ack_o, 4'b0000);
        s_ack_i = 1'b0;
        step();
        check("drop gnt0", gnt_o, 4'b0001);

        // Asynchronous reset while master 0 strobes
        s_ack_i = 1'b1;
        #1;
        check("rst pre ack", m_ack_o, 4'b0001);
        rst = 1'b1;
        #1;
        idle_checks("rst async");
        step();
        rst     = 1'b0;
        s_ack_i = 1'b0;
        m_cyc_i = 4'b0101;
        m_stb_i = 4'b0101;
        step();
        check("rst first gnt", gnt_o, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdrc_wb_arbiter.md
SDRC_WB_ARBITER -- requirements
Module: sdrc_wb_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_M, default 4, meaning number of Wishbone requesters (2..8).
REQ-002 The module SHALL have parameter AW, default 26, meaning address width.
REQ-003 The module SHALL have parameter DW, default 32, meaning data width; the select width is DW/8.
REQ-004 The module SHALL have parameter TIMEOUT, default 255, meaning the number of stall cycles before an error is signalled.
REQ-005 The module SHALL have one clock and an asynchronous, active-high reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  reset.
REQ-006 The module SHALL have the following master ports, with vector fields packed by requester index:
- m_cyc_i  in  NUM_M  per-master cycle
- m_stb_i  in  NUM_M  per-master strobe
- m_we_i  in  NUM_M  per-master write enable
- m_adr_i  in  NUM_M*AW  packed addresses
- m_dat_i  in  NUM_M*DW  packed write data
- m_sel_i  in  NUM_M*DW/8  packed byte selects
- m_dat_o  out  DW  read data, shared by all masters
- m_ack_o  out  NUM_M  per-master acknowledge
- m_err_o  out  NUM_M  per-master error
REQ-007 The module SHALL have the following slave ports, facing the SDRAM controller:
- s_cyc_o  out  1
- s_stb_o  out  1
- s_we_o  out  1
- s_adr_o  out  AW
- s_dat_o  out  DW
- s_sel_o  out  DW/8
- s_dat_i  in  DW
- s_ack_i  in  1
REQ-008 The module SHALL have the following status ports:
- gnt_o  out  NUM_M  one-hot grant
- busy_o  out  1  high while not IDLE

Function
REQ-009 The FSM SHALL have three states:
- IDLE
- OWN: a master holds the bus
- ERR: timeout
REQ-010 In IDLE, if any m_cyc_i is high at a clock edge, the FSM SHALL select one requester, register it into gnt_o, and enter OWN; gnt_o is visible one cycle after the request.
REQ-011 Selection SHALL be round-robin: search starts at index rr_ptr, wrapping modulo NUM_M, and the first requester with m_cyc_i high wins.
REQ-012 On grant, rr_ptr SHALL load (granted index + 1) mod NUM_M; for example, grant of index NUM_M-1 sets rr_ptr to 0.
REQ-013 In OWN, the slave outputs SHALL combinationally mux the granted master's signals:
- s_cyc_o = m_cyc_i[g]
- s_stb_o = m_stb_i[g]
- s_we_o, s_adr_o, s_dat_o, s_sel_o from master g
REQ-014 Outside OWN, s_cyc_o and s_stb_o SHALL be 0, and s_we_o, s_adr_o, s_dat_o and s_sel_o SHALL be 0.
REQ-015 m_ack_o[g] SHALL equal s_ack_i AND gnt_o[g] AND (state==OWN); all other ack bits SHALL be 0; zero added latency.
REQ-016 m_dat_o SHALL equal s_dat_i unconditionally.
REQ-017 The owner SHALL keep the grant across multiple stb/ack beats for as long as its m_cyc_i stays high (bus lock for bursts).
REQ-018 When m_cyc_i[g] is low at a clock edge in OWN, the FSM SHALL clear gnt_o and return to IDLE; re-arbitration occurs on the following edge, giving exactly one dead cycle between owners.
REQ-019 If s_ack_i and the drop of m_cyc_i[g] occur in the same cycle, the ack SHALL still be delivered to g, then the grant is released.
REQ-020 Requests from non-owners SHALL be ignored, with no ack and no err, until arbitration.
REQ-021 An 8-bit-or-wider stall counter SHALL clear on entry to OWN and on any s_ack_i, and SHALL increment each OWN cycle with s_stb_o=1 and s_ack_i=0; it SHALL saturate and never wrap.
REQ-022 When the stall counter equals TIMEOUT, the FSM SHALL enter ERR on the next edge.
REQ-023 In ERR, m_err_o[g] SHALL be high only in the first ERR cycle, s_cyc_o and s_stb_o SHALL be 0, and gnt_o SHALL remain held.
REQ-024 The FSM SHALL leave ERR for IDLE when m_cyc_i[g] is low, clearing gnt_o.
REQ-025 A late s_ack_i in ERR or IDLE SHALL be dropped.
REQ-026 busy_o SHALL be high whenever the state is not IDLE.

Reset
REQ-027 While wb_rst_i is high, asynchronously, the module SHALL drive state=IDLE, gnt_o=0, rr_ptr=0, stall counter=0, m_ack_o=0, m_err_o=0, s_cyc_o=0, s_stb_o=0 and busy_o=0.
REQ-028 Reset asserted mid-transaction SHALL abort immediately with no ack or err pulse.
REQ-029 After reset release, the first arbitration SHALL search from index 0.

Verification
REQ-030 Single request: m_cyc_i=4'b0100 at cycle 0 -> gnt_o=4'b0100 at cycle 1, s_cyc_o=1 at cycle 1; s_ack_i pulse -> m_ack_o=4'b0100 in the same cycle.
REQ-031 Fairness: all four masters hold cyc high, each dropping after one ack -> grant order 0,1,2,3,0 with one dead cycle between grants.
REQ-032 Burst lock: master 1 performs 8 beats with cyc held while master 0 requests -> master 0 receives no grant until master 1 drops cyc.
REQ-033 Timeout: TIMEOUT=15, master 2 strobes with no ack -> m_err_o=4'b0100 for one cycle after 15 stall cycles, s_stb_o=0; master 2 drops cyc -> IDLE.
REQ-034 Simultaneous ack and cyc drop by master 3 with master 0 pending -> master 3 acked, then one IDLE cycle, then gnt_o=4'b0001.
REQ-035 Reset during OWN with stb high -> all outputs 0 asynchronously; after release, simultaneous requests from masters 2 and 0 -> master 0 granted first.
